// File: rtl/ntt_seq_pkg.sv
// ntt_seq_pkg: shared FSM state, mode and butterfly opcode definitions for the NTT issue sequencer.
package ntt_seq_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;
    localparam logic [1:0] BTF_OP_BF  = 2'd0;
    localparam logic [1:0] BTF_OP_MUL = 2'd1;
    localparam logic [1:0] BTF_OP_ADD = 2'd2;
    localparam logic [1:0] BTF_OP_SUB = 2'd3;
endpackage

// File: rtl/btf_seq_addrgen.sv
// btf_seq_addrgen: combinational operand/twiddle address generator for one butterfly (stage s, op k).
module btf_seq_addrgen
    import ntt_seq_pkg::*;
#(
    parameter int LOGN = 8,
    parameter int SW   = $clog2(LOGN)
) (
    input  logic [SW-1:0]   s_i,
    input  logic [LOGN-2:0] k_i,
    input  logic            mode_i,
    output logic [LOGN-1:0] a_o,
    output logic [LOGN-1:0] b_o,
    output logic [LOGN-1:0] tw_o
);
    int              lt;
    logic [LOGN-1:0] kx;
    logic [LOGN-1:0] i;
    // lt = log2(t); in both modes m = 1 << (LOGN-1-lt)
    always_comb begin
        lt   = (mode_i == MODE_INV) ? int'(s_i) : LOGN - 1 - int'(s_i);
        kx   = LOGN'(k_i);
        i    = kx >> lt;
        a_o  = (i << (lt + 1)) | (kx & ((LOGN'(1) << lt) - LOGN'(1)));
        b_o  = a_o | (LOGN'(1) << lt);
        tw_o = (LOGN'(1) << (LOGN - 1 - lt)) + i;
    end
endmodule

// File: rtl/ntt_btf_seq.sv
// ntt_btf_seq: issue-side sequencer running one in-place NTT/INTT through the butterfly pipeline.
// Define NTT_BTF_SEQ_PERF_EN to add the perf_cycles busy-cycle counter output.
module ntt_btf_seq
    import ntt_seq_pkg::*;
#(
    parameter int LOGN       = 8,
    parameter int BTF_LAT    = 7,
    parameter int MEM_RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
`ifdef NTT_BTF_SEQ_PERF_EN
    output logic [31:0]     perf_cycles,
`endif
    input  logic            start,
    input  logic            mode,
    input  logic            hold,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] tw_addr,
    output logic [1:0]      btf_opcode,
    output logic            btf_dif_dit,
    output logic            btf_div_by_2,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);
    localparam int D  = MEM_RD_LAT + BTF_LAT;
    localparam int SW = $clog2(LOGN);
    localparam int IW = $clog2(D + 1);

    state_t            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [LOGN-2:0]   k_q, k_d;
    logic              mode_q, mode_d;
    logic [IW-1:0]     infl_q, infl_d;
    logic [D-1:0]      vld_q;
    logic [LOGN-1:0]   wa_q [D];
    logic [LOGN-1:0]   wb_q [D];
    logic [LOGN-1:0]   a, b, tw;

    btf_seq_addrgen #(.LOGN(LOGN), .SW(SW)) u_addrgen (
        .s_i(s_q), .k_i(k_q), .mode_i(mode_q), .a_o(a), .b_o(b), .tw_o(tw)
    );

    assign rd_en        = (state_q == ISSUE) && !hold;
    assign wr_en        = vld_q[D-1];
    assign busy         = state_q != IDLE;
    assign done         = state_q == FINISH;
    assign rd_addr_a    = rd_en ? a : '0;
    assign rd_addr_b    = rd_en ? b : '0;
    assign tw_addr      = rd_en ? tw : '0;
    assign btf_opcode   = BTF_OP_BF;
    assign btf_dif_dit  = rd_en && (mode_q == MODE_FWD);
    assign btf_div_by_2 = rd_en && (mode_q == MODE_INV);
    assign wr_addr_a    = wr_en ? wa_q[D-1] : '0;
    assign wr_addr_b    = wr_en ? wb_q[D-1] : '0;
    assign infl_d       = infl_q + IW'(rd_en) - IW'(wr_en);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ISSUE;
                mode_d  = mode;
                s_d     = '0;
                k_d     = '0;
            end
            ISSUE: if (!hold) begin
                k_d     = k_q + 1'b1;
                state_d = (k_q == {(LOGN-1){1'b1}}) ? DRAIN : ISSUE;
            end
            // leave as the final write of the stage leaves the pipeline
            DRAIN: if (infl_d == '0) begin
                state_d = (s_q == SW'(LOGN - 1)) ? FINISH : ISSUE;
                s_d     = (s_q == SW'(LOGN - 1)) ? s_q : s_q + 1'b1;
                k_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            mode_q  <= MODE_FWD;
            infl_q  <= '0;
            vld_q   <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            k_q      <= k_d;
            mode_q   <= mode_d;
            infl_q   <= infl_d;
            vld_q[0] <= rd_en;
            for (int i = 1; i < D; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        wa_q[0] <= a;
        wb_q[0] <= b;
        for (int i = 1; i < D; i++) begin
            wa_q[i] <= wa_q[i-1];
            wb_q[i] <= wb_q[i-1];
        end
    end

`ifdef NTT_BTF_SEQ_PERF_EN
    logic [31:0] perf_q;
    assign perf_cycles = perf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_q <= '0;
        else if (state_q == IDLE && start) perf_q <= '0;
        else if (state_q != IDLE) perf_q <= perf_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ntt_btf_seq.sv
// tb_ntt_btf_seq: scoreboard bench for ntt_btf_seq at LOGN=3, BTF_LAT=2, MEM_RD_LAT=1 (D=3).
module tb_ntt_btf_seq;
    localparam int LOGN = 3;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, hold = 1'b0;
    logic busy, done, rd_en, btf_dif_dit, btf_div_by_2, wr_en;
    logic [LOGN-1:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;
    logic [1:0] btf_opcode;
`ifdef NTT_BTF_SEQ_PERF_EN
    logic [31:0] perf_cycles;
`endif

    ntt_btf_seq #(.LOGN(LOGN), .BTF_LAT(2), .MEM_RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
`ifdef NTT_BTF_SEQ_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .start(start), .mode(mode), .hold(hold), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .btf_opcode(btf_opcode), .btf_dif_dit(btf_dif_dit), .btf_div_by_2(btf_div_by_2),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int a; int b; int tw; int dd; int d2;} ev_t;
    ev_t rdq[$], wrq[$];
    int  doneq[$];
    int  cyc = 0, t0 = 0, n_cmp = 0, n_bad = 0, wr_cnt = 0, done_cnt = 0;

    // hand-derived schedules: forward/inverse operand pairs and read cycles
    int fa[12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
    int fb[12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
    int ft[12] = '{1,1,1,1, 2,2,3,3, 4,5,6,7};
    int ia[12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
    int ib[12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
    int it[12] = '{4,5,6,7, 2,2,3,3, 1,1,1,1};
    int nc[12] = '{1,2,3,4, 8,9,10,11, 15,16,17,18};
    int hc[12] = '{1,4,5,6, 10,11,12,13, 17,18,19,20};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t0);
        end
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (rd_en) begin
            if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                e = rdq.pop_front();
                chk("rd_cycle", cyc - t0, e.cyc);
                chk("rd_addr_a", int'(rd_addr_a), e.a);
                chk("rd_addr_b", int'(rd_addr_b), e.b);
                chk("tw_addr", int'(tw_addr), e.tw);
                chk("btf_ctl", int'({btf_opcode, btf_dif_dit, btf_div_by_2}), e.dd * 2 + e.d2);
            end
        end
        if (wr_en) begin
            wr_cnt++;
            if (wrq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                e = wrq.pop_front();
                chk("wr_cycle", cyc - t0, e.cyc);
                chk("wr_addr_a", int'(wr_addr_a), e.a);
                chk("wr_addr_b", int'(wr_addr_b), e.b);
            end
        end
        if (done) begin
            done_cnt++;
            if (doneq.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_cycle", cyc - t0, doneq.pop_front());
        end
    end

    task automatic push(input int n, input bit inv, input bit hld, input bit rd, input bit wr);
        ev_t e;
        e.cyc = hld ? hc[n] : nc[n];
        e.a   = inv ? ia[n] : fa[n];
        e.b   = inv ? ib[n] : fb[n];
        e.tw  = inv ? it[n] : ft[n];
        e.dd  = inv ? 0 : 1;
        e.d2  = inv ? 1 : 0;
        if (rd) rdq.push_back(e);
        e.cyc = e.cyc + 3;
        if (wr) wrq.push_back(e);
    endtask

    task automatic check_quiet(string name);
        chk(name, int'({busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, btf_opcode,
                         btf_dif_dit, btf_div_by_2, wr_en, wr_addr_a, wr_addr_b}), 0);
    endtask

    task automatic run(input bit inv, input bit hld, input bit pulse5);
        for (int n = 0; n < 12; n++) push(n, inv, hld, 1'b1, 1'b1);
        doneq.push_back(hld ? 24 : 22);
        wr_cnt   = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        t0 = cyc; start = 1'b1; mode = inv;
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk); #1;
            start = pulse5 && (c == 5);
            hold  = hld && (c == 2 || c == 3);
        end
        chk("rd_queue_left", rdq.size(), 0);
        chk("wr_queue_left", wrq.size(), 0);
        chk("done_queue_left", doneq.size(), 0);
        chk("wr_count", wr_cnt, 12);
        chk("done_count", done_cnt, 1);
        chk("busy_after", int'(busy), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_quiet("reset_outputs");
        rst = 1'b0;
        run(1'b0, 1'b0, 1'b0);
`ifdef NTT_BTF_SEQ_PERF_EN
        chk("perf_fwd", int'(perf_cycles), 22);
`endif
        run(1'b1, 1'b0, 1'b0);
        run(1'b0, 1'b1, 1'b0);
`ifdef NTT_BTF_SEQ_PERF_EN
        chk("perf_hold", int'(perf_cycles), 24);
`endif
        run(1'b0, 1'b0, 1'b1);
        // abort a forward run at cycle 9, then restart cleanly at cycle 12
        for (int n = 0; n < 5; n++) push(n, 1'b0, 1'b0, 1'b1, n < 4);
        @(posedge clk); #1;
        t0 = cyc; start = 1'b1; mode = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        #1 check_quiet("abort_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_rd_left", rdq.size(), 0);
        chk("abort_wr_left", wrq.size(), 0);
        run(1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
